regfile_op_sequencer: RTL and testbench

- Initiator-side controller for the 8-bit register file.
- Accepts one 16-bit register-to-register instruction per valid/ready handshake.
- Drives the register file read addresses, samples both read data ports, computes an 8-bit ALU result, then issues a single-cycle write back.
- Sits between the instruction source (fetch/decode) and the register file; strictly serial, one instruction in flight, so it has no hazards.

---
 rtl/regseq_pkg.sv | 58 +++++
 rtl/regseq_alu.sv | 57 +++++
 rtl/regfile_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file op sequencer: sizes, opcodes,
// FSM states, instruction field positions and opcode classification helpers.
package regseq_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;
  localparam int DEF_IW = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'd0;
  localparam opcode_t OP_ADD = 4'd1;
  localparam opcode_t OP_SUB = 4'd2;
  localparam opcode_t OP_AND = 4'd3;
  localparam opcode_t OP_OR  = 4'd4;
  localparam opcode_t OP_XOR = 4'd5;
  localparam opcode_t OP_MOV = 4'd6;
  localparam opcode_t OP_LDI = 4'd7;
  localparam opcode_t OP_SHL = 4'd8;
  localparam opcode_t OP_SHR = 4'd9;
  localparam opcode_t OP_CMP = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } state_t;

  // NOP and LDI need no register operands, so they skip the read cycle.
  function automatic logic op_skips_read(opcode_t op);
    return (op == OP_NOP) || (op == OP_LDI);
  endfunction

  function automatic logic op_writes(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic op_sets_flags(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP};
  endfunction

  function automatic logic op_illegal(opcode_t op);
    return op > OP_CMP;
  endfunction

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the op sequencer: result, carry/borrow and zero
// from the latched opcode, operand registers and immediate.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  opcode_t         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   imm,
  output logic [DW-1:0]   result,
  output logic            c,
  output logic            z
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DW-1:0];
        c      = sum[DW];
      end
      // Bit DW of the widened difference is the borrow out.
      OP_SUB, OP_CMP: begin
        result = diff[DW-1:0];
        c      = diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
      end
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/regfile_op_sequencer.sv
// Serial register-to-register instruction sequencer driving an 8-bit register file.
// Define REGSEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky err flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for an instruction (unless an illegal-op trap is pending)
// ST_READ  | rs1/rs2 on rf_a1/rf_a2; operands captured at cycle end
// ST_EXEC  | ALU evaluates; flags update; NOP/CMP/illegal retire here
// ST_WRITE | single-cycle write back of result to rd, done pulses
module regfile_op_sequencer
  import regseq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [AW-1:0] rf_a1,
  output logic [AW-1:0] rf_a2,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic          rf_we,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c,
  output logic          err,
  input  logic          err_clr
);

  state_t        state;
  state_t        state_nxt;
  opcode_t       op_q;
  opcode_t       op_in;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_z;
  logic          hs;
  logic          err_set;

  assign op_in = instr[OP_HI:OP_LO];
  assign hs    = instr_valid && instr_ready;

  regseq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z)
  );

`ifdef REGSEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign err = err_q;
`else
  localparam bit TRAP_EN = 1'b0;
  logic unused_trap;

  assign unused_trap = err_clr | err_set;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    err_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = !err;
        if (instr_valid && instr_ready)
          state_nxt = op_skips_read(op_in) ? ST_EXEC : ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op_writes(op_q)) begin
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_IDLE;
          if (TRAP_EN && op_illegal(op_q)) err_set = 1'b1;
          else                             done    = 1'b1;
        end
      end
      ST_WRITE: begin
        rf_we     = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      rd_q   <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rf_a1  <= '0;
      rf_a2  <= '0;
      rf_a3  <= '0;
      rf_wd  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q  <= op_in;
        rd_q  <= instr[RD_HI:RD_LO];
        imm_q <= instr[IMM_HI:IMM_LO];
        if (!op_skips_read(op_in)) begin
          rf_a1 <= instr[RS1_HI:RS1_LO];
          rf_a2 <= instr[RS2_HI:RS2_LO];
        end
      end
      if (state == ST_READ) begin
        a_q <= rf_rd1;
        b_q <= rf_rd2;
      end
      // Write-back address/data are staged here so they sit stable during ST_WRITE.
      if (state == ST_EXEC) begin
        if (op_writes(op_q)) begin
          rf_a3 <= rd_q;
          rf_wd <= alu_res;
        end
        if (op_sets_flags(op_q)) begin
          flag_z <= alu_z;
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register file plus an arithmetic
// reference model of the instruction set, directed and randomized scenarios.
module tb_regfile_op_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready, rf_we, done, flag_z, flag_c, err;
  logic [2:0]  rf_a1, rf_a2, rf_a3;
  logic [7:0]  rf_wd, rf_rd1, rf_rd2;
  logic [7:0]  rf_mem [8];

  int n_cmp = 0;
  int n_bad = 0;

  int m_reg [8];
  bit m_z = 1'b0;
  bit m_c = 1'b0;

  always #5 clock = ~clock;

  assign rf_rd1 = rf_mem[rf_a1];
  assign rf_rd2 = rf_mem[rf_a2];
  always @(posedge clock) if (rf_we) rf_mem[rf_a3] <= rf_wd;

  regfile_op_sequencer dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_we(rf_we),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .done(done), .flag_z(flag_z), .flag_c(flag_c),
    .err(err), .err_clr(err_clr)
  );

  function automatic logic [15:0] mk(int op, int rd, int rs1, int rs2);
    logic [15:0] w;
    w = {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
    return w;
  endfunction

  function automatic logic [15:0] mk_ldi(int rd, int imm);
    logic [15:0] w;
    w = {4'd7, rd[2:0], 1'b0, imm[7:0]};
    return w;
  endfunction

  // Reference model: expected write, data and retire cycle (counted from the accept edge).
  task automatic model_op(input logic [15:0] ins, output bit e_we, output int e_wd,
                          output int e_lat, output bit e_done);
    int op, rd, rs1, rs2, imm, a, b, r;
    bit fl;
    op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3]; imm = ins[7:0];
    a = m_reg[rs1]; b = m_reg[rs2];
    r = 0; fl = 0; e_we = 0; e_done = 1;
    e_lat = (op == 0 || op == 7) ? 1 : 2;
    case (op)
      0: ;
      1: begin r = a + b; m_c = (r > 255); r = r % 256; fl = 1; e_we = 1; end
      2: begin m_c = (a < b); r = (a - b + 256) % 256; fl = 1; e_we = 1; end
      3: begin r = a & b; m_c = 0; fl = 1; e_we = 1; end
      4: begin r = a | b; m_c = 0; fl = 1; e_we = 1; end
      5: begin r = a ^ b; m_c = 0; fl = 1; e_we = 1; end
      6: begin r = a; e_we = 1; end
      7: begin r = imm; e_we = 1; end
      8: begin r = (a * 2) % 256; m_c = (a >= 128); fl = 1; e_we = 1; end
      9: begin r = a / 2; m_c = (a % 2 == 1); fl = 1; e_we = 1; end
      10: begin m_c = (a < b); r = (a - b + 256) % 256; fl = 1; end
      default: begin
`ifdef REGSEQ_ILLEGAL_TRAP_EN
        e_done = 0;
`endif
      end
    endcase
    if (fl) m_z = (r == 0);
    if (e_we) begin m_reg[rd] = r; e_lat = e_lat + 1; end
    e_wd = r;
  endtask

  // Offers one instruction, then watches it until done (bounded) and reports what it saw.
  task automatic run_op(input logic [15:0] ins, output int we_cnt, output int we_cyc,
                        output logic [2:0] a3_o, output logic [7:0] wd_o, output int done_cnt,
                        output int done_cyc, output int rdy_hi, output bit hs_to);
    we_cnt = 0; we_cyc = -1; a3_o = 'x; wd_o = 'x; done_cnt = 0; done_cyc = -1; rdy_hi = 0; hs_to = 1;
    instr = ins; instr_valid = 1'b1;
    for (int g = 0; g < 20; g++) begin
      @(negedge clock);
      if (instr_ready) begin hs_to = 0; break; end
    end
    @(posedge clock); #1;
    instr_valid = 1'b0;
    if (hs_to) return;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (instr_ready) rdy_hi++;
      if (rf_we) begin we_cnt++; we_cyc = cyc; a3_o = rf_a3; wd_o = rf_wd; end
      if (done) begin done_cnt++; done_cyc = cyc; break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", instr_ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", rf_we); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if ({flag_z, flag_c} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {flag_z, flag_c}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if ({rf_a1, rf_a2, rf_a3, rf_wd} !== 17'h0) begin n_bad++; $display("FAIL reset_addr_data got %h want 0", {rf_a1, rf_a2, rf_a3, rf_wd}); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_z = 0; m_c = 0;
  endtask

  task automatic test_ldi_add();
    logic [15:0] prog [3];
    bit e_we, e_done; int e_wd, e_lat;
    int we_cnt, we_cyc, done_cnt, done_cyc, rdy_hi; bit to; logic [2:0] a3; logic [7:0] wd;
    prog[0] = mk_ldi(1, 8'hF0); prog[1] = mk_ldi(2, 8'h20); prog[2] = mk(1, 3, 1, 2);
    for (int i = 0; i < 3; i++) begin
      model_op(prog[i], e_we, e_wd, e_lat, e_done);
      run_op(prog[i], we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
      n_cmp++; if (we_cyc !== (i < 2 ? 2 : 3)) begin n_bad++; $display("FAIL ldi_add_we_cycle op%0d got %0d want %0d", i, we_cyc, (i < 2 ? 2 : 3)); end
    end
    n_cmp++; if (a3 !== 3'd3) begin n_bad++; $display("FAIL add_a3 got %0d want 3", a3); end
    n_cmp++; if (wd !== 8'h10) begin n_bad++; $display("FAIL add_wd got %h want 10", wd); end
    n_cmp++; if ({flag_z, flag_c} !== 2'b01) begin n_bad++; $display("FAIL add_flags zc got %b want 01", {flag_z, flag_c}); end
  endtask

  task automatic test_sub_zero();
    bit e_we, e_done; int e_wd, e_lat;
    int we_cnt, we_cyc, done_cnt, done_cyc, rdy_hi; bit to; logic [2:0] a3; logic [7:0] wd;
    model_op(mk_ldi(4, 8'h55), e_we, e_wd, e_lat, e_done);
    run_op(mk_ldi(4, 8'h55), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    model_op(mk(2, 5, 4, 4), e_we, e_wd, e_lat, e_done);
    run_op(mk(2, 5, 4, 4), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    n_cmp++; if ({a3, wd} !== {3'd5, 8'h00}) begin n_bad++; $display("FAIL sub_zero a3/wd got %0d/%h want 5/00", a3, wd); end
    n_cmp++; if ({flag_z, flag_c} !== 2'b10) begin n_bad++; $display("FAIL sub_zero_flags zc got %b want 10", {flag_z, flag_c}); end
  endtask

  task automatic test_cmp_borrow();
    bit e_we, e_done; int e_wd, e_lat;
    int we_cnt, we_cyc, done_cnt, done_cyc, rdy_hi; bit to; logic [2:0] a3; logic [7:0] wd;
    model_op(mk_ldi(1, 1), e_we, e_wd, e_lat, e_done);
    run_op(mk_ldi(1, 1), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    model_op(mk_ldi(2, 2), e_we, e_wd, e_lat, e_done);
    run_op(mk_ldi(2, 2), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    model_op(mk(10, 0, 1, 2), e_we, e_wd, e_lat, e_done);
    run_op(mk(10, 0, 1, 2), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    n_cmp++; if (we_cnt !== 0) begin n_bad++; $display("FAIL cmp_no_write got %0d writes want 0", we_cnt); end
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL cmp_done_cycle got %0d want 2", done_cyc); end
    n_cmp++; if ({flag_z, flag_c} !== 2'b01) begin n_bad++; $display("FAIL cmp_flags zc got %b want 01", {flag_z, flag_c}); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    bit e_we, e_done; int e_wd, e_lat;
    int we_cnt, we_cyc, done_cnt, done_cyc, rdy_hi; bit to; logic [2:0] a3; logic [7:0] wd;
    for (int i = 0; i < 48; i++) begin
      if (i < 8) ins = mk_ldi(i, $urandom_range(0, 255));
      else begin
        ins = mk($urandom_range(0, 10), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        if (ins[15:12] == 4'd7) ins[7:0] = 8'($urandom);
      end
      model_op(ins, e_we, e_wd, e_lat, e_done);
      run_op(ins, we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rand_accept_timeout ins %h", ins); end
      n_cmp++; if (we_cnt !== int'(e_we)) begin n_bad++; $display("FAIL rand_we_count ins %h got %0d want %0d", ins, we_cnt, e_we); end
      if (e_we) begin
        n_cmp++; if (we_cyc !== e_lat) begin n_bad++; $display("FAIL rand_we_cycle ins %h got %0d want %0d", ins, we_cyc, e_lat); end
        n_cmp++; if (a3 !== ins[11:9]) begin n_bad++; $display("FAIL rand_a3 ins %h got %0d want %0d", ins, a3, ins[11:9]); end
        n_cmp++; if (wd !== 8'(e_wd)) begin n_bad++; $display("FAIL rand_wd ins %h got %h want %h", ins, wd, 8'(e_wd)); end
      end
      n_cmp++; if (done_cyc !== e_lat) begin n_bad++; $display("FAIL rand_done_cycle ins %h got %0d want %0d", ins, done_cyc, e_lat); end
      n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL rand_ready_busy ins %h got %0d high cycles want 0", ins, rdy_hi); end
      n_cmp++; if ({flag_z, flag_c} !== {m_z, m_c}) begin n_bad++; $display("FAIL rand_flags ins %h got %b want %b", ins, {flag_z, flag_c}, {m_z, m_c}); end
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++; if (rf_mem[r] !== 8'(m_reg[r])) begin n_bad++; $display("FAIL rand_regfile r%0d got %h want %h", r, rf_mem[r], 8'(m_reg[r])); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [5];
    bit e_we [5]; int e_wd [5]; int e_lat [5]; bit e_done;
    int acc_t [5]; logic [2:0] wa [8]; logic [7:0] wv [8];
    int idx, wcount; bit hs;
    q[0] = mk(1, 6, 1, 2); q[1] = mk(5, 7, 6, 3); q[2] = mk_ldi(0, 8'h3C);
    q[3] = mk_ldi(5, 8'hA7); q[4] = mk(2, 4, 5, 0);
    for (int i = 0; i < 5; i++) model_op(q[i], e_we[i], e_wd[i], e_lat[i], e_done);
    idx = 0; wcount = 0; instr = q[0]; instr_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clock);
      if (rf_we) begin if (wcount < 8) begin wa[wcount] = rf_a3; wv[wcount] = rf_wd; end wcount++; end
      hs = instr_ready && instr_valid;
      @(posedge clock); #1;
      if (hs) begin
        acc_t[idx] = t; idx++;
        if (idx < 5) instr = q[idx]; else instr_valid = 1'b0;
      end
      if (idx == 5 && t >= acc_t[4] + 4) break;
    end
    instr_valid = 1'b0;
    n_cmp++; if (idx !== 5) begin n_bad++; $display("FAIL b2b_accepts got %0d want 5", idx); end
    for (int i = 0; i < 4; i++) if (idx == 5) begin
      n_cmp++; if (acc_t[i+1] - acc_t[i] !== e_lat[i] + 1) begin n_bad++; $display("FAIL b2b_gap %0d got %0d want %0d", i, acc_t[i+1] - acc_t[i], e_lat[i] + 1); end
    end
    n_cmp++; if (wcount !== 5) begin n_bad++; $display("FAIL b2b_write_count got %0d want 5", wcount); end
    for (int i = 0; i < 5; i++) if (i < wcount) begin
      n_cmp++; if ({wa[i], wv[i]} !== {q[i][11:9], 8'(e_wd[i])}) begin n_bad++; $display("FAIL b2b_write %0d got %0d/%h want %0d/%h", i, wa[i], wv[i], q[i][11:9], 8'(e_wd[i])); end
    end
    n_cmp++; if ({flag_z, flag_c} !== {m_z, m_c}) begin n_bad++; $display("FAIL b2b_flags got %b want %b", {flag_z, flag_c}, {m_z, m_c}); end
  endtask

  task automatic test_mid_reset();
    int we_seen, done_seen; bit to;
    we_seen = 0; done_seen = 0; to = 1;
    instr = mk(1, 3, 1, 2); instr_valid = 1'b1;
    for (int g = 0; g < 20; g++) begin @(negedge clock); if (instr_ready) begin to = 0; break; end end
    @(posedge clock); #1;
    instr_valid = 1'b0;
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (rf_we) we_seen++;
      if (done) done_seen++;
    end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL midrst_accept_timeout"); end
    n_cmp++; if (we_seen + done_seen !== 0) begin n_bad++; $display("FAIL midrst_activity got we=%0d done=%0d want 0/0", we_seen, done_seen); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got ready %b want 1", instr_ready); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_z = 0; m_c = 0;
    repeat (3) @(negedge clock);
    n_cmp++; if ({rf_we, done, instr_ready} !== 3'b001) begin n_bad++; $display("FAIL midrst_after got we/done/ready %b want 001", {rf_we, done, instr_ready}); end
    @(posedge clock); #1;
  endtask

  task automatic test_illegal();
    bit e_we, e_done; int e_wd, e_lat;
    int we_cnt, we_cyc, done_cnt, done_cyc, rdy_hi; bit to; logic [2:0] a3; logic [7:0] wd;
    model_op(mk(12, 2, 1, 3), e_we, e_wd, e_lat, e_done);
    run_op(mk(12, 2, 1, 3), we_cnt, we_cyc, a3, wd, done_cnt, done_cyc, rdy_hi, to);
    n_cmp++; if (we_cnt !== 0) begin n_bad++; $display("FAIL illegal_write got %0d want 0", we_cnt); end
    n_cmp++; if (done_cnt !== int'(e_done)) begin n_bad++; $display("FAIL illegal_done got %0d want %0d", done_cnt, e_done); end
    n_cmp++; if ({flag_z, flag_c} !== {m_z, m_c}) begin n_bad++; $display("FAIL illegal_flags got %b want %b", {flag_z, flag_c}, {m_z, m_c}); end
`ifdef REGSEQ_ILLEGAL_TRAP_EN
    n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL trap_ready_during got %0d want 0", rdy_hi); end
    @(negedge clock);
    n_cmp++; if ({err, instr_ready} !== 2'b10) begin n_bad++; $display("FAIL trap_hold err/ready got %b want 10", {err, instr_ready}); end
    @(posedge clock); #1;
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    @(negedge clock);
    n_cmp++; if ({err, instr_ready} !== 2'b01) begin n_bad++; $display("FAIL trap_clear err/ready got %b want 01", {err, instr_ready}); end
    @(posedge clock); #1;
`else
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL illegal_done_cycle got %0d want 2", done_cyc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal_err got %b want 0", err); end
`endif
  endtask

  initial begin
    for (int r = 0; r < 8; r++) m_reg[r] = 0;
    test_reset();
    test_ldi_add();
    test_sub_zero();
    test_cmp_borrow();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
